// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (core / loader) arbiter and access sequencer for the
//            unified memory, with wait-state handshake and timeout guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_c_req,
    input  logic          i_c_we,
    input  logic [AW-1:0] i_c_addr,
    input  logic [DW-1:0] i_c_wdata,
    output logic          o_c_done,
    output logic          o_c_err,
    output logic [DW-1:0] o_c_rdata,
    input  logic          i_l_req,
    input  logic          i_l_we,
    input  logic [AW-1:0] i_l_addr,
    input  logic [DW-1:0] i_l_wdata,
    output logic          o_l_done,
    output logic          o_l_err,
    output logic [DW-1:0] o_l_rdata,
    output logic [1:0]    o_gnt,
    output logic          o_busy,
    output logic          o_m_en,
    output logic          o_m_we,
    output logic [AW-1:0] o_m_addr,
    output logic [DW-1:0] o_m_wdata,
    input  logic [DW-1:0] i_m_rdata,
    input  logic          i_m_ready
);

    typedef enum logic [1:0] {
        c_ST_IDLE   = 2'd0,
        c_ST_ACCESS = 2'd1,
        c_ST_DONE   = 2'd2
    } state_t;

    localparam int                   c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_owner_l;   // 0 = core, 1 = loader
    logic                r_last_l;    // port served last; reset to loader so core wins first tie
    logic                r_we;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_err;
    logic [DW-1:0]       r_c_rdata;
    logic [DW-1:0]       r_l_rdata;

    logic w_any_req;
    logic w_pick_l;
    logic w_access;
    logic w_done;

    assign w_any_req = i_c_req | i_l_req;
    assign w_pick_l  = i_l_req & (~i_c_req | ~r_last_l);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= c_ST_IDLE;
            r_owner_l <= 1'b0;
            r_last_l  <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wait    <= '0;
            r_err     <= 1'b0;
            r_c_rdata <= '0;
            r_l_rdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner_l <= w_pick_l;
                        r_we      <= w_pick_l ? i_l_we    : i_c_we;
                        r_addr    <= w_pick_l ? i_l_addr  : i_c_addr;
                        r_wdata   <= w_pick_l ? i_l_wdata : i_c_wdata;
                        r_wait    <= '0;
                        r_err     <= 1'b0;
                        r_state   <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: begin
                    if (i_m_ready) begin
                        r_err <= 1'b0;
                        if (!r_we) begin
                            if (r_owner_l) r_l_rdata <= i_m_rdata;
                            else           r_c_rdata <= i_m_rdata;
                        end
                        r_state <= c_ST_DONE;
                    end else if (r_wait == c_WAIT_LAST) begin
                        // Timed-out reads return zero rather than stale data
                        r_err <= 1'b1;
                        if (!r_we) begin
                            if (r_owner_l) r_l_rdata <= '0;
                            else           r_c_rdata <= '0;
                        end
                        r_state <= c_ST_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_last_l <= r_owner_l;
                    r_state  <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_access  = (r_state == c_ST_ACCESS);
    assign w_done    = (r_state == c_ST_DONE);

    assign o_busy    = (r_state != c_ST_IDLE);
    assign o_gnt     = o_busy ? {r_owner_l, ~r_owner_l} : 2'b00;
    assign o_m_en    = w_access;
    assign o_m_we    = w_access & r_we;
    assign o_m_addr  = w_access ? r_addr  : '0;
    assign o_m_wdata = w_access ? r_wdata : '0;

    assign o_c_done  = w_done & ~r_owner_l;
    assign o_l_done  = w_done &  r_owner_l;
    assign o_c_err   = o_c_done & r_err;
    assign o_l_err   = o_l_done & r_err;
    assign o_c_rdata = r_c_rdata;
    assign o_l_rdata = r_l_rdata;

endmodule

`default_nettype wire
